// File: rtl/rv32_cpu_cp_div_ctrl.sv
// rv32_cpu_cp_div_ctrl: issue/return controller in front of the serial divider co-processor
module rv32_cpu_cp_div_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_cpu_trap,
  output logic [XLEN-1:0] o_res,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_err,
  output logic            o_div_start,
  output logic [2:0]      o_div_op,
  output logic [XLEN-1:0] o_div_rs1,
  output logic [XLEN-1:0] o_div_rs2,
  output logic            o_div_trap,
  input  logic [XLEN-1:0] i_div_res,
  input  logic            i_div_valid
);
  typedef enum logic [2:0] {IDLE, FAST, ISSUE, WAIT, DONE, FLUSH} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t          r_state, w_next;
  logic [15:0]     r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_rs1, r_rs2, r_res;
  logic            r_err;
  logic            w_acc, w_zero, w_ovf, w_tmo;
  logic [XLEN-1:0] w_fast_res;
  assign w_acc      = r_state == IDLE && i_valid && i_funct3[2];
  assign w_zero     = i_rs2 == '0;
  assign w_ovf      = !i_funct3[0] && i_rs1 == {1'b1, {(XLEN-1){1'b0}}} && i_rs2 == '1;
  // funct3[1] selects remainder; special results follow the RV32M rules
  assign w_fast_res = w_zero ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
  assign w_tmo      = r_cnt == LAST;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? ((w_zero || w_ovf) ? FAST : ISSUE) : IDLE;
      FAST:    w_next = IDLE;
      ISSUE:   w_next = i_cpu_trap ? FLUSH : WAIT;
      WAIT:    w_next = i_div_valid ? DONE : ((i_cpu_trap || w_tmo) ? FLUSH : WAIT);
      DONE:    w_next = IDLE;
      FLUSH:   w_next = (i_div_valid || w_tmo) ? IDLE : FLUSH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_res <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= ((r_state == WAIT || r_state == FLUSH) && w_next == r_state) ? r_cnt + 16'd1 : '0;
      if (w_acc) begin
        r_op  <= i_funct3;
        r_rs1 <= i_rs1;
        r_rs2 <= i_rs2;
        r_res <= w_fast_res;
      end else if (r_state == WAIT && i_div_valid) begin
        r_res <= i_div_res;
      end
      r_err <= (r_state == WAIT && !i_div_valid && w_tmo) ? 1'b1 : (r_state == IDLE ? 1'b0 : r_err);
    end
  assign o_res       = r_res;
  assign o_valid     = r_state == FAST || r_state == DONE;
  assign o_busy      = r_state != IDLE;
  assign o_err       = r_state == IDLE && r_err;
  assign o_div_start = r_state == ISSUE;
  assign o_div_op    = r_op;
  assign o_div_rs1   = r_rs1;
  assign o_div_rs2   = r_rs2;
  assign o_div_trap  = r_state == FLUSH;
endmodule

// File: tb/tb_rv32_cpu_cp_div_ctrl.sv
// tb_rv32_cpu_cp_div_ctrl: randomized bench with a transaction-level timing/result model and stub divider
module tb_rv32_cpu_cp_div_ctrl;
  localparam int TMO = 40;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic        clk = 0, rst = 1;
  logic        i_valid = 0, i_cpu_trap = 0, i_div_valid = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_rs1 = 0, i_rs2 = 0, i_div_res = 0;
  logic [31:0] o_res, o_div_rs1, o_div_rs2;
  logic        o_valid, o_busy, o_err, o_div_start, o_div_trap;
  logic [2:0]  o_div_op;
  logic        exp_busy = 0, exp_valid = 0, exp_start = 0, exp_trap = 0, exp_err = 0, pend_err = 0, chk = 0;
  logic [31:0] exp_res = 0, exp_rs1 = 0, exp_rs2 = 0;
  logic [2:0]  exp_op = 0;
  int          vectors = 0, miscompares = 0;

  rv32_cpu_cp_div_ctrl #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_cpu_trap(i_cpu_trap), .o_res(o_res), .o_valid(o_valid), .o_busy(o_busy), .o_err(o_err),
    .o_div_start(o_div_start), .o_div_op(o_div_op), .o_div_rs1(o_div_rs1), .o_div_rs2(o_div_rs2),
    .o_div_trap(o_div_trap), .i_div_res(i_div_res), .i_div_valid(i_div_valid));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == MIN && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
    case (f[1:0])
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk) begin
    check("busy", 32'(o_busy), 32'(exp_busy));
    check("valid", 32'(o_valid), 32'(exp_valid));
    check("start", 32'(o_div_start), 32'(exp_start));
    check("div_trap", 32'(o_div_trap), 32'(exp_trap));
    check("err", 32'(o_err), 32'(exp_err));
    check("div_op", 32'(o_div_op), 32'(exp_op));
    check("div_rs1", o_div_rs1, exp_rs1);
    check("div_rs2", o_div_rs2, exp_rs2);
    if (exp_valid || rst) check("res", o_res, exp_res);
  end

  task automatic tick();
    @(posedge clk); #1;
    i_valid = 0; i_cpu_trap = 0; i_div_valid = 0; i_div_res = $urandom; i_funct3 = 3'($urandom);
    exp_valid = 0; exp_start = 0; exp_trap = 0; exp_err = 0; exp_busy = 1;
  endtask

  task automatic idle_cyc(input bit noise);
    tick();
    exp_busy = 0; exp_err = pend_err; pend_err = 0;
    i_valid = noise;
    i_funct3 = {1'b0, 2'($urandom)};
  endtask

  // d: WAIT cycle in which the stub divider answers (-1 never); t: WAIT cycle of CPU trap (-1 none)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int d, input int t);
    bit fast, tmo;
    int w;
    tick();
    exp_busy = 0; exp_err = pend_err; pend_err = 0;
    i_valid = 1; i_funct3 = f; i_rs1 = a; i_rs2 = b;
    fast = b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF);
    tick();
    exp_op = f; exp_rs1 = a; exp_rs2 = b;
    if (fast) begin
      exp_valid = 1; exp_res = r; i_cpu_trap = 1'($urandom);
      return;
    end
    exp_start = 1;
    for (w = 0; w < TMO; w++) begin
      tick();
      if (w == d) begin
        i_div_valid = 1; i_div_res = r;
        tick();
        exp_valid = 1; exp_res = r; i_cpu_trap = 1'($urandom);
        return;
      end
      if (w == t || w == TMO - 1) break;
    end
    i_cpu_trap = w == t;
    tmo = w == TMO - 1;
    for (int k = 0; k < TMO; k++) begin
      tick();
      exp_trap = 1;
      if (d >= 0 && d == w + 1 + k) begin
        i_div_valid = 1;
        break;
      end
    end
    pend_err = tmo;
  endtask

  initial begin
    chk = 1;
    repeat (2) @(negedge clk);
    tick();
    rst = 0; exp_busy = 0;
    idle_cyc(0);
    run_op(3'b101, 100, 7, 14, 6, -1);
    run_op(3'b111, 100, 7, 2, 3, -1);
    run_op(3'b100, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 10, -1);
    run_op(3'b110, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 0, -1);
    run_op(3'b100, 5, 0, 32'hFFFF_FFFF, -1, -1);
    run_op(3'b111, 5, 0, 5, -1, -1);
    run_op(3'b100, MIN, 32'hFFFF_FFFF, MIN, -1, -1);
    run_op(3'b110, MIN, 32'hFFFF_FFFF, 0, -1, -1);
    run_op(3'b101, MIN, 32'hFFFF_FFFF, 0, 4, -1);
    run_op(3'b101, 20, 4, 5, 12, 5);
    run_op(3'b101, 9, 3, 3, 2, -1);
    run_op(3'b101, 9, 3, 3, -1, -1);
    idle_cyc(0);
    run_op(3'b100, 1, 1, 1, 39, -1);
    // reset in the middle of WAIT
    tick(); exp_busy = 0; i_valid = 1; i_funct3 = 3'b101; i_rs1 = 50; i_rs2 = 5;
    tick(); exp_op = 3'b101; exp_rs1 = 50; exp_rs2 = 5; exp_start = 1;
    repeat (3) tick();
    tick();
    rst = 1; exp_busy = 0; exp_op = 0; exp_rs1 = 0; exp_rs2 = 0; exp_res = 0; pend_err = 0;
    tick();
    rst = 0; exp_busy = 0;
    repeat (3) idle_cyc(1);
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int m, d, t;
      f = {1'b1, 2'($urandom)};
      m = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (m == 0) b = 0;
      else if (m == 1) begin a = MIN; b = 32'hFFFF_FFFF; end
      else if (m < 5) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 30); end
      else if (m == 5) b = 32'($signed(-$urandom_range(1, 30)));
      d = ($urandom_range(0, 24) == 0) ? -1 : $urandom_range(0, 45);
      t = ($urandom_range(0, 4) == 0 && d > 0) ? $urandom_range(0, d - 1) : -1;
      run_op(f, a, b, ref_div(f, a, b), d, t);
      repeat ($urandom_range(0, 2)) idle_cyc(1'($urandom));
    end
    idle_cyc(0);
    idle_cyc(0);
    @(negedge clk);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
